// File: rtl/traffic_corridor_ctrl_pkg.sv
// traffic_pkg: shared types and constants for the corridor controller.
// Holds phase encoding, lamp aspects, lamp indices and phase helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_N = 3'd0,
        NRTH_GRN = 3'd1,
        NRTH_YLW = 3'd2,
        ALLRED_W = 3'd3,
        WEST_GRN = 3'd4,
        WEST_YLW = 3'd5
    } state_t;

    // bit positions inside one {red,ylw,grn} lamp triple
    localparam int LAMP_GRN = 0;
    localparam int LAMP_YLW = 1;
    localparam int LAMP_RED = 2;

    localparam logic [2:0] RED = 3'(1 << LAMP_RED);
    localparam logic [2:0] YLW = 3'(1 << LAMP_YLW);
    localparam logic [2:0] GRN = 3'(1 << LAMP_GRN);

    // pedestrian direction index
    localparam int NDIR  = 2;
    localparam int DIR_N = 0;
    localparam int DIR_W = 1;

    function automatic state_t next_state(state_t s);
        state_t n;
        unique case (s)
            ALLRED_N: n = NRTH_GRN;
            NRTH_GRN: n = NRTH_YLW;
            NRTH_YLW: n = ALLRED_W;
            ALLRED_W: n = WEST_GRN;
            WEST_GRN: n = WEST_YLW;
            default:  n = ALLRED_N;
        endcase
        return n;
    endfunction

    // aspect shown on one approach; west mirrors north
    function automatic logic [2:0] aspect(state_t s, logic west);
        logic [2:0] a;
        a = RED;
        unique case (1'b1)
            (s == NRTH_GRN && !west),
            (s == WEST_GRN &&  west): a = GRN;
            (s == NRTH_YLW && !west),
            (s == WEST_YLW &&  west): a = YLW;
            default:                  a = RED;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/traffic_corridor_ctrl_if.sv
// Corridor lamp/button bundle between controller and its surroundings.
// master: controller side (buttons in, lamps and tick out); slave: peer.
interface traffic_corridor_ctrl_if #(
    parameter int NUM_INT = 2
);
    import traffic_pkg::*;

    logic                   nrth_ped_req;
    logic                   west_ped_req;
    logic [3*NUM_INT-1:0]   light_nrth;
    logic [3*NUM_INT-1:0]   light_west;
    logic [NUM_INT-1:0]     walk_nrth;
    logic [NUM_INT-1:0]     stop_nrth;
    logic [NUM_INT-1:0]     walk_west;
    logic [NUM_INT-1:0]     stop_west;
    logic                   tick_out;

    modport master (
        input  nrth_ped_req, west_ped_req,
        output light_nrth, light_west,
        output walk_nrth, stop_nrth,
        output walk_west, stop_west,
        output tick_out
    );

    modport slave (
        output nrth_ped_req, west_ped_req,
        input  light_nrth, light_west,
        input  walk_nrth, stop_nrth,
        input  walk_west, stop_west,
        input  tick_out
    );

endinterface

// File: rtl/traffic_corridor_ctrl_tick_gen.sv
// tick_gen: divides clk by TICK_DIV and emits a one-cycle tick pulse.
// Ports: clk, rst_n (async low), tick (high while counter == TICK_DIV-1).
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_corridor_ctrl.sv
// traffic_corridor_ctrl: one phase FSM driving NUM_INT identical intersections.
// Ports: clk_50_mhz, reset_n (async low), bus (master: buttons in, lamps out).
// Optional PED_FLASH_EN: stop lamp flashes during yellow after a served walk.
module traffic_corridor_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_INT      = 2,
    parameter int TICK_DIV     = 50000000,
    parameter int GRN_TICKS    = 20,
    parameter int YLW_TICKS    = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 10,
    parameter int CNT_W        = 8
) (
    input  logic                   clk_50_mhz,
    input  logic                   reset_n,
    traffic_corridor_ctrl_if.master bus
);

    logic               tick;
    state_t             state;
    state_t             nxt;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   dur_m1;
    logic               adv;
    logic [2:0]         asp_n;
    logic [2:0]         asp_w;

    logic [NDIR-1:0]    req_in;
    logic [NDIR-1:0]    req_lat;
    logic [NDIR-1:0]    serve;
    logic [NDIR-1:0]    enter_g;
    logic [NDIR-1:0]    walk_act;
    logic [NDIR-1:0]    stop_lvl;
    logic [CNT_W-1:0]   wcnt [NDIR];

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk_50_mhz),
        .rst_n (reset_n),
        .tick  (tick)
    );

    always_comb begin
        dur_m1 = CNT_W'(ALLRED_TICKS - 1);
        unique case (state)
            NRTH_GRN, WEST_GRN: dur_m1 = CNT_W'(GRN_TICKS - 1);
            NRTH_YLW, WEST_YLW: dur_m1 = CNT_W'(YLW_TICKS - 1);
            default:            dur_m1 = CNT_W'(ALLRED_TICKS - 1);
        endcase
    end

    assign nxt = next_state(state);
    assign adv = tick && (phase_cnt == dur_m1);

    // lamps are registered from the next state so they switch with it
    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ALLRED_N;
            phase_cnt <= '0;
            asp_n     <= RED;
            asp_w     <= RED;
        end else if (adv) begin
            state     <= nxt;
            phase_cnt <= '0;
            asp_n     <= aspect(nxt, 1'b0);
            asp_w     <= aspect(nxt, 1'b1);
        end else if (tick) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    assign req_in  = {bus.west_ped_req, bus.nrth_ped_req};
    // a press on the green-entry edge itself is served, not re-latched
    assign serve   = req_lat | req_in;
    assign enter_g = {adv && (nxt == WEST_GRN), adv && (nxt == NRTH_GRN)};

    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            req_lat  <= '0;
            walk_act <= '0;
            for (int d = 0; d < NDIR; d++) wcnt[d] <= '0;
        end else begin
            for (int d = 0; d < NDIR; d++) begin
                if (enter_g[d]) begin
                    walk_act[d] <= serve[d];
                    req_lat[d]  <= 1'b0;
                    wcnt[d]     <= '0;
                end else begin
                    if (req_in[d]) req_lat[d] <= 1'b1;
                    if (tick && walk_act[d]) begin
                        if (wcnt[d] == CNT_W'(WALK_TICKS - 1))
                            walk_act[d] <= 1'b0;
                        else
                            wcnt[d] <= wcnt[d] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PED_FLASH_EN
    logic [NDIR-1:0] served;
    logic [NDIR-1:0] flash;
    logic [NDIR-1:0] in_ylw;
    logic [NDIR-1:0] enter_y;

    assign in_ylw  = {state == WEST_YLW, state == NRTH_YLW};
    assign enter_y = {adv && (nxt == WEST_YLW), adv && (nxt == NRTH_YLW)};

    // served remembers whether this green gave a walk; flash is the
    // stop phase during the following yellow, starting lit
    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            served <= '0;
            flash  <= '1;
        end else begin
            for (int d = 0; d < NDIR; d++) begin
                if (enter_g[d]) served[d] <= serve[d];
                if (enter_y[d])
                    flash[d] <= 1'b1;
                else if (tick && in_ylw[d])
                    flash[d] <= ~flash[d];
            end
        end
    end

    assign stop_lvl = ~walk_act & (~(in_ylw & served) | flash);
`else
    assign stop_lvl = ~walk_act;
`endif

    for (genvar i = 0; i < NUM_INT; i++) begin : g_int
        assign bus.light_nrth[3*i +: 3] = asp_n;
        assign bus.light_west[3*i +: 3] = asp_w;
        assign bus.walk_nrth[i]         = walk_act[DIR_N];
        assign bus.stop_nrth[i]         = stop_lvl[DIR_N];
        assign bus.walk_west[i]         = walk_act[DIR_W];
        assign bus.stop_west[i]         = stop_lvl[DIR_W];
    end

    assign bus.tick_out = tick;

endmodule

// File: tb/tb_traffic_corridor_ctrl.sv
// Bench for traffic_corridor_ctrl: tick-position reference model feeds a
// scoreboard queue each clock; outputs are popped and compared on negedge.
module tb_traffic_corridor_ctrl;

    localparam int NI  = 3;
    localparam int DIV = 4;
    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    typedef struct packed {
        logic [3*NI-1:0] ln;
        logic [3*NI-1:0] lw;
        logic [NI-1:0]   wn;
        logic [NI-1:0]   sn;
        logic [NI-1:0]   ww;
        logic [NI-1:0]   sw;
        logic            tk;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    int   m_c;
    bit   m_lat[2];
    bit   m_g[2];
    int   m_st[2];

    traffic_corridor_ctrl_if #(.NUM_INT(NI)) bus ();

    traffic_corridor_ctrl #(
        .NUM_INT      (NI),
        .TICK_DIV     (DIV),
        .GRN_TICKS    (5),
        .YLW_TICKS    (2),
        .ALLRED_TICKS (1),
        .WALK_TICKS   (3),
        .CNT_W        (8)
    ) dut (
        .clk_50_mhz (clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // aspects by position p (0..15) in the 16-tick corridor cycle
    function automatic logic [2:0] asp_at(int p, bit west);
        if (!west) begin
            if (p >= 1 && p <= 5) return L_G;
            if (p == 6 || p == 7) return L_Y;
            return L_R;
        end
        if (p >= 9 && p <= 13) return L_G;
        if (p == 14 || p == 15) return L_Y;
        return L_R;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   k;
        int   p;
        bit   rq;
        bit   ent;
        bit   wn;
        bit   ww;
        bit   sn;
        bit   sw;
        if (!rst_n) begin
            m_c = 0;
            for (int d = 0; d < 2; d++) begin
                m_lat[d] = 0;
                m_g[d]   = 0;
                m_st[d]  = -100;
            end
        end else begin
            m_c++;
            k = m_c / DIV;
            p = k % 16;
            for (int d = 0; d < 2; d++) begin
                rq  = (d == 0) ? bus.nrth_ped_req : bus.west_ped_req;
                ent = (m_c % DIV == 0) && (p == ((d == 0) ? 1 : 9));
                if (ent) begin
                    m_g[d]   = m_lat[d] | rq;
                    m_st[d]  = m_g[d] ? k : -100;
                    m_lat[d] = 0;
                end else if (rq) begin
                    m_lat[d] = 1;
                end
            end
        end
        k  = m_c / DIV;
        p  = k % 16;
        wn = (p >= 1 && p <= 5) && (k - m_st[0] < 3);
        ww = (p >= 9 && p <= 13) && (k - m_st[1] < 3);
`ifdef PED_FLASH_EN
        sn = !wn && !(m_g[0] && p == 7);
        sw = !ww && !(m_g[1] && p == 15);
`else
        sn = !wn;
        sw = !ww;
`endif
        e.ln = {NI{asp_at(p, 1'b0)}};
        e.lw = {NI{asp_at(p, 1'b1)}};
        e.wn = {NI{wn}};
        e.sn = {NI{sn}};
        e.ww = {NI{ww}};
        e.sw = {NI{sw}};
        e.tk = (m_c % DIV == DIV - 1);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("light_nrth", 32'(bus.light_nrth), 32'(e.ln));
            chk("light_west", 32'(bus.light_west), 32'(e.lw));
            chk("walk_nrth",  32'(bus.walk_nrth),  32'(e.wn));
            chk("stop_nrth",  32'(bus.stop_nrth),  32'(e.sn));
            chk("walk_west",  32'(bus.walk_west),  32'(e.ww));
            chk("stop_west",  32'(bus.stop_west),  32'(e.sw));
            chk("tick_out",   32'(bus.tick_out),   32'(e.tk));
        end
    end

    // wait until the model is at tick position pp, cycle sub within the tick
    task automatic wait_at(input int pp, input int sub);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(((m_c / DIV) % 16 == pp) && (m_c % DIV == sub))
                   && n < 200);
        chk("wait_bound", 32'(n < 200), 32'd1);
    endtask

    task automatic pulse_n();
        bus.nrth_ped_req = 1'b1;
        @(negedge clk);
        bus.nrth_ped_req = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.nrth_ped_req = 1'b0;
        bus.west_ped_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_light_n", 32'(bus.light_nrth), 32'o444);
        chk("rst_stop_w",  32'(bus.stop_west),  32'b111);
        rst_n = 1'b1;

        // idle corridor: two full cycles
        repeat (128) @(negedge clk);

        // single north press during west green
        wait_at(10, 1);
        pulse_n();
        repeat (128) @(negedge clk);

        // west held for 40 ticks
        bus.west_ped_req = 1'b1;
        repeat (40 * DIV) @(negedge clk);
        bus.west_ped_req = 1'b0;
        repeat (64) @(negedge clk);

        // press exactly on the green-entry edge, then nothing next cycle
        wait_at(0, 3);
        pulse_n();
        wait_at(8, 0);
        wait_at(0, 3);
        wait_at(8, 0);
        // entry press plus a re-press at walk tick 1
        wait_at(0, 3);
        pulse_n();
        wait_at(2, 0);
        pulse_n();
        repeat (128) @(negedge clk);

        // reset during west yellow with north pending
        wait_at(10, 1);
        pulse_n();
        wait_at(14, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_light_n", 32'(bus.light_nrth), 32'o444);
        chk("arst_light_w", 32'(bus.light_west), 32'o444);
        chk("arst_stop_n",  32'(bus.stop_nrth),  32'b111);
        chk("arst_walk_n",  32'(bus.walk_nrth),  32'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
